// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// register-port address map.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] MASK = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] ISR  = 2'd2;
    localparam logic [1:0] STAT = 2'd3;

endpackage

// File: rtl/prio_encoder.sv
// Fixed-priority encoder: reports the lowest-index set bit of req and
// whether any bit is set.
module prio_encoder #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        idx   = '0;
        valid = |req;
        // Walk downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered IRQ/NMI collector with fixed-priority arbitration, CPU
// acknowledge handshake, in-service tracking and a small register port.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          N_IRQ      = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter logic [31:0] NMI_VEC    = 32'h0000_0080,
    parameter logic [31:0] SPUR_VEC   = 32'h0000_00F0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             nmi_in,
    input  logic             isInterrupted,
    input  logic             INA,
    input  logic             eoi,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic             INT,
    output logic             NMI,
    output logic [31:0]      vector,
    output logic             spurious
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_t           state, next_state;
    logic [N_IRQ-1:0] mask, pending, in_service, irq_q;
    logic             nmi_q, nmi_pend, armed;
    logic [N_IRQ-1:0] eligible, irq_edge, ack_clr, w1c;
    logic [IW-1:0]    winner;
    logic             winner_valid, nmi_edge;
    logic             int_ack, nmi_ack, spur_ack;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, cfg_wdata};

    // The history registers come out of reset at 0; armed masks the first
    // post-reset cycle so lines held high across reset do not look like edges.
    assign irq_edge = armed ? (irq & ~irq_q) : '0;
    assign nmi_edge = armed & nmi_in & ~nmi_q;

    assign eligible = pending & ~mask;

    prio_encoder #(.N(N_IRQ), .IW(IW)) u_prio (
        .req   (eligible),
        .idx   (winner),
        .valid (winner_valid)
    );

    assign int_ack  = isInterrupted & INA & (state == REQ) & winner_valid;
    assign nmi_ack  = isInterrupted & ~INA & nmi_pend;
    assign spur_ack = isInterrupted & ~int_ack & ~nmi_ack;

    assign ack_clr = int_ack ? (N_IRQ'(1) << winner) : '0;
    assign w1c     = (cfg_we && cfg_addr == PEND) ? cfg_wdata[N_IRQ-1:0] : '0;

    assign NMI = nmi_pend;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (winner_valid) next_state = REQ;
            REQ: begin
                if (int_ack)            next_state = SERVICE;
                else if (!winner_valid) next_state = IDLE;
            end
            SERVICE: if (eoi) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            mask       <= '1;
            pending    <= '0;
            in_service <= '0;
            irq_q      <= '0;
            nmi_q      <= 1'b0;
            nmi_pend   <= 1'b0;
            armed      <= 1'b0;
            INT        <= 1'b0;
            vector     <= '0;
            spurious   <= 1'b0;
        end else begin
            state    <= next_state;
            irq_q    <= irq;
            nmi_q    <= nmi_in;
            armed    <= 1'b1;
            // INT rises one cycle after entering REQ and drops on the edge that leaves it.
            INT      <= (state == REQ) && (next_state == REQ);
            spurious <= spur_ack;

            if (cfg_we && cfg_addr == MASK) mask <= cfg_wdata[N_IRQ-1:0];

            // New edges are OR-ed in last so a set beats an ack or W1C clear.
            pending  <= (pending & ~(w1c | ack_clr)) | irq_edge;
            nmi_pend <= (nmi_pend & ~nmi_ack) | nmi_edge;

            if (state == SERVICE && eoi) in_service <= '0;
            else if (int_ack)            in_service <= in_service | ack_clr;

            if (int_ack)       vector <= VEC_BASE + 32'(winner) * VEC_STRIDE;
            else if (nmi_ack)  vector <= NMI_VEC;
            else if (spur_ack) vector <= SPUR_VEC;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            MASK:    cfg_rdata = 16'(mask);
            PEND:    cfg_rdata = 16'(pending);
            ISR:     cfg_rdata = 16'(in_service);
            STAT:    cfg_rdata = {13'b0, nmi_pend, state};
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default parameters).
module tb_interrupt_controller;
    import intc_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  irq;
    logic        nmi_in, isInterrupted, INA, eoi, cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata, cfg_rdata;
    logic        INT, NMI, spurious;
    logic [31:0] vector;

    int n_cmp = 0;
    int n_bad = 0;

    interrupt_controller dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .irq           (irq),
        .nmi_in        (nmi_in),
        .isInterrupted (isInterrupted),
        .INA           (INA),
        .eoi           (eoi),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .INT           (INT),
        .NMI           (NMI),
        .vector        (vector),
        .spurious      (spurious)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check(tag, 32'(cfg_rdata), exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        irq = irq | bits;
        tick();
        irq = irq & ~bits;
    endtask

    task automatic pulse_nmi();
        nmi_in = 1'b1;
        tick();
        nmi_in = 1'b0;
    endtask

    task automatic ack(input logic ina);
        isInterrupted = 1'b1; INA = ina;
        tick();
        isInterrupted = 1'b0; INA = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; irq = '0; nmi_in = 0; isInterrupted = 0; INA = 0; eoi = 0;
        cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
        tick(2);
        Reset = 1'b0;

        // Reset values
        check("rst_int", 32'(INT), 0);
        check("rst_nmi", 32'(NMI), 0);
        check("rst_vec", vector, 0);
        check("rst_spur", 32'(spurious), 0);
        check_reg("rst_mask", MASK, 32'hFF);
        check_reg("rst_pend", PEND, 0);
        check_reg("rst_isr", ISR, 0);
        check_reg("rst_stat", STAT, 0);

        // IRQ0: INT two cycles after the sampled edge
        wr(MASK, 16'h00FE);
        pulse_irq(8'h01);
        check_reg("t1_pend", PEND, 32'h01);
        check("t1_int_early", 32'(INT), 0);
        tick();
        check_reg("t1_stat_req", STAT, 32'h1);
        check("t1_int_entry", 32'(INT), 0);
        tick();
        check("t1_int", 32'(INT), 1);
        ack(1'b1);
        check("t1_vec", vector, 32'h100);
        check("t1_int_off", 32'(INT), 0);
        check_reg("t1_isr", ISR, 32'h01);
        check_reg("t1_pend_clr", PEND, 0);
        check_reg("t1_stat_svc", STAT, 32'h2);
        do_eoi();
        check_reg("t1_stat_idle", STAT, 0);
        check_reg("t1_isr_clr", ISR, 0);

        // IRQ5 and IRQ2 together: priority, then re-request after eoi
        wr(MASK, 16'h0000);
        pulse_irq(8'h24);
        tick(2);
        check("t2_int", 32'(INT), 1);
        ack(1'b1);
        check("t2_vec1", vector, 32'h120);
        check_reg("t2_pend", PEND, 32'h20);
        check_reg("t2_isr", ISR, 32'h04);
        do_eoi();
        tick(2);
        check("t2_int_again", 32'(INT), 1);
        ack(1'b1);
        check("t2_vec2", vector, 32'h150);
        check_reg("t2_pend_empty", PEND, 0);
        do_eoi();

        // NMI while servicing IRQ3
        pulse_irq(8'h08);
        tick(2);
        ack(1'b1);
        check("t3_vec_irq3", vector, 32'h130);
        pulse_nmi();
        check("t3_nmi", 32'(NMI), 1);
        check("t3_int_held", 32'(INT), 0);
        check_reg("t3_stat", STAT, 32'h6);
        ack(1'b0);
        check("t3_vec_nmi", vector, 32'h80);
        check("t3_nmi_off", 32'(NMI), 0);
        check_reg("t3_isr", ISR, 32'h08);
        check_reg("t3_stat_svc", STAT, 32'h2);
        do_eoi();
        check_reg("t3_stat_idle", STAT, 0);

        // Spurious acks in IDLE with a masked pending line
        wr(MASK, 16'h00FF);
        pulse_irq(8'h40);
        ack(1'b1);
        check("t4_vec", vector, 32'hF0);
        check("t4_spur", 32'(spurious), 1);
        check_reg("t4_pend", PEND, 32'h40);
        check_reg("t4_isr", ISR, 0);
        check_reg("t4_stat", STAT, 0);
        tick();
        check("t4_spur_1cyc", 32'(spurious), 0);
        ack(1'b0);
        check("t4_spur_nmi", 32'(spurious), 1);
        do_eoi();
        check_reg("t4_eoi_idle", STAT, 0);
        check_reg("t4_eoi_pend", PEND, 32'h40);
        wr(PEND, 16'h0040);
        check_reg("t4_w1c", PEND, 0);

        // eoi and ack in the same cycle: ack is spurious
        wr(MASK, 16'h0000);
        pulse_irq(8'h80);
        tick(2);
        ack(1'b1);
        check("t5_vec_irq7", vector, 32'h170);
        eoi = 1'b1; isInterrupted = 1'b1; INA = 1'b1;
        tick();
        eoi = 1'b0; isInterrupted = 1'b0; INA = 1'b0;
        check("t5_spur", 32'(spurious), 1);
        check("t5_vec", vector, 32'hF0);
        check_reg("t5_stat", STAT, 0);
        check_reg("t5_isr", ISR, 0);

        // Masking the requesting line withdraws INT
        pulse_irq(8'h02);
        tick(2);
        check("t6_int", 32'(INT), 1);
        check_reg("t6_stat_req", STAT, 32'h1);
        wr(MASK, 16'h0002);
        tick();
        check("t6_int_off", 32'(INT), 0);
        check_reg("t6_stat_idle", STAT, 0);
        check_reg("t6_pend", PEND, 32'h02);
        wr(PEND, 16'h0002);
        check_reg("t6_w1c", PEND, 0);
        // W1C and a new edge on the same bit: the set wins
        irq = 8'h02; cfg_we = 1'b1; cfg_addr = PEND; cfg_wdata = 16'h0002;
        tick();
        cfg_we = 1'b0; irq = '0;
        check_reg("t6_set_wins", PEND, 32'h02);
        wr(PEND, 16'h0002);

        // Reset mid-SERVICE with irq4 held high
        wr(MASK, 16'h0000);
        irq = 8'h10;
        tick(3);
        ack(1'b1);
        check("t7_vec_irq4", vector, 32'h140);
        pulse_nmi();
        check("t7_nmi_pre", 32'(NMI), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t7_int", 32'(INT), 0);
        check("t7_nmi", 32'(NMI), 0);
        check("t7_vec", vector, 0);
        check_reg("t7_mask", MASK, 32'hFF);
        check_reg("t7_pend", PEND, 0);
        check_reg("t7_isr", ISR, 0);
        check_reg("t7_stat", STAT, 0);
        wr(MASK, 16'h0000);
        tick(3);
        check_reg("t7_no_edge", PEND, 0);
        check("t7_no_int", 32'(INT), 0);
        irq = '0;
        tick();
        pulse_irq(8'h10);
        check_reg("t7_fresh", PEND, 32'h10);
        tick(2);
        check("t7_fresh_int", 32'(INT), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Peripheral-side end of the CPU interrupt handshake: collects external IRQ lines and an NMI line, arbitrates them by fixed priority, and drives INT/NMI into the multicycle MIPS controller.
- Consumes the CPU's acknowledge (isInterrupted with INA qualifier) and supplies the handler vector.
- Tracks in-service state until software signals end-of-interrupt (EOI).
- Provides a small register port for mask and pending access.

Parameters:
- N_IRQ, 8, number of maskable IRQ inputs (2..16).
- VEC_BASE, 32'h0000_0100, vector of IRQ0.
- VEC_STRIDE, 32'h10, vector spacing per IRQ id.
- NMI_VEC, 32'h0000_0080, vector for NMI.
- SPUR_VEC, 32'h0000_00F0, vector returned on a spurious acknowledge.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- irq  in  N_IRQ  rising-edge-triggered requests, already synchronous to Clk; bit 0 has highest priority.
- nmi_in  in  1  rising-edge-triggered non-maskable request.
- isInterrupted  in  1  one-cycle pulse: CPU is taking an interrupt.
- INA  in  1  valid with isInterrupted: 1 = maskable taken, 0 = NMI taken.
- eoi  in  1  one-cycle end-of-interrupt pulse.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select.
- cfg_wdata  in  16  write data; upper bits above N_IRQ ignored.
- cfg_rdata  out  16  combinational read data.
- INT  out  1  maskable request to CPU.
- NMI  out  1  non-maskable request to CPU.
- vector  out  32  handler address, registered.
- spurious  out  1  one-cycle flag.

Behaviour:
- Reset values: mask=all 1 (all masked), pending=0, in_service=0, nmi_pend=0, INT=0, NMI=0, vector=0, spurious=0, edge-history registers=0, state=IDLE.
- Edge detect: pending[i] sets on cycle k+1 when irq[i] is 1 at k and 0 at k-1. nmi_pend sets the same way from nmi_in.
- eligible = pending & ~mask. winner = lowest-index set bit of eligible.
- Maskable FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, go to REQ.
  - REQ: INT=1 (registered; 1 cycle after entry). If eligible becomes 0 (mask write, W1C), return to IDLE and INT=0 next cycle. On isInterrupted&INA: latch in_service[winner]=1, clear pending[winner], vector=VEC_BASE+winner*VEC_STRIDE, INT=0, go to SERVICE.
  - SERVICE: INT held 0 (no nesting). On eoi: clear in_service, go to IDLE. eligible is re-evaluated the following cycle.
- NMI path, independent of the FSM and mask:
  - NMI=1 while nmi_pend.
  - On isInterrupted&~INA with nmi_pend: clear nmi_pend, vector=NMI_VEC, NMI=0 next cycle. The FSM state is unchanged.
  - A new nmi_in edge while NMI=1 merges into the pending request (not counted).
- Spurious acknowledge: isInterrupted with nothing matching (INA=1 and state!=REQ or eligible=0; INA=0 and nmi_pend=0) produces vector=SPUR_VEC and spurious=1 for one cycle. No other state changes.
- Simultaneous events:
  - New edge on the line being acked in the same cycle: set wins, so pending stays 1.
  - eoi and ack in the same cycle: eoi is applied first (SERVICE→IDLE). The ack is then spurious, since INT was 0.
  - W1C on pending and an edge on the same bit: set wins.
- eoi outside SERVICE is ignored.
- Register map (cfg_addr):
  - 0: mask, R/W.
  - 1: pending, read; write-1-to-clear.
  - 2: in_service, read-only.
  - 3: status {13'b0, nmi_pend, state[1:0]}, read-only.
- Writes take effect on the next edge. Unused read bits are 0.
- Vector arithmetic is unsigned 32-bit, with overflow ignored.
- Reset asserted in any state: all state returns to reset values on that edge, and INT/NMI are 0 the next cycle. irq lines held high across reset are not treated as edges after reset.

Decomposition:
- Shared package intc_pkg holds:
  - state encoding: IDLE=0, REQ=1, SERVICE=2;
  - register address constants: MASK=0, PEND=1, ISR=2, STAT=3.
- One sub-module is natural: prio_encoder (N_IRQ-wide, lowest-index-first, outputs index and valid). It is reused later by the CPU-side exception cause logic.

Test Plan:
- Reset, write mask=8'hFE, pulse irq[0] → INT=1 two cycles after the edge. Ack with INA=1 → vector=32'h100, INT=0, in_service=8'h01. eoi → state=IDLE.
- Mask=0, irq[5] and irq[2] rise in the same cycle → ack gives vector=32'h120, pending=8'h20. eoi → INT reasserts; second ack gives vector=32'h150.
- In SERVICE with IRQ3, pulse nmi_in → NMI=1 while INT stays 0. Ack with INA=0 → vector=32'h80, NMI=0, in_service still 8'h08.
- Ack with INA=1 while IDLE → vector=32'hF0, spurious=1 for 1 cycle, pending/in_service unchanged.
- In REQ on irq[1], write mask bit 1 → INT=0 next cycle, state=IDLE. Write 1 to PEND bit 1 → pending=0.
- Reset mid-SERVICE with irq[4] held high → all regs at reset values, INT/NMI=0, no pending after unmasking until a fresh rising edge.
